// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - AXI-Lite channel bundle used by every arbiter port
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master AXI-Lite arbiter, independent read/write paths
// AXI_LITE_ARB_FIXED_PRIO_EN selects fixed priority (master0 wins) instead of round-robin.
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input  logic            clk,
    input  logic            rstn,
    axi_lite_channel.slave  master0,
    axi_lite_channel.slave  master1,
    axi_lite_channel.master slave
);
    if ($bits(master0.aw_addr) != ADDR_WIDTH || $bits(master1.aw_addr) != ADDR_WIDTH ||
        $bits(slave.aw_addr) != ADDR_WIDTH) begin : g_addr_mismatch
        $fatal(1, "axi_lite_arbiter: interface address width differs from ADDR_WIDTH");
    end
    if ($bits(master0.w_data) != DATA_WIDTH || $bits(master1.w_data) != DATA_WIDTH ||
        $bits(slave.w_data) != DATA_WIDTH) begin : g_data_mismatch
        $fatal(1, "axi_lite_arbiter: interface data width differs from DATA_WIDTH");
    end

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    logic    wgnt, rgnt;
    logic    aw_done, w_done;
    logic    wgnt_next, rgnt_next;
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
    logic    wprio, rprio;
`endif

    // Grant choice only matters in IDLE; the chosen master is registered before anything is forwarded.
    always_comb begin
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
        wgnt_next = !master0.aw_valid;
        rgnt_next = !master0.ar_valid;
`else
        wgnt_next = (master0.aw_valid && master1.aw_valid) ? wprio : master1.aw_valid;
        rgnt_next = (master0.ar_valid && master1.ar_valid) ? rprio : master1.ar_valid;
`endif
    end

    logic aw_fwd, w_fwd, w_resp_ph, r_addr_ph, r_resp_ph;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_fwd    = (wstate == W_ADDR) && !aw_done;
    assign w_fwd     = (wstate == W_ADDR) && !w_done;
    assign w_resp_ph = (wstate == W_RESP);
    assign r_addr_ph = (rstate == R_ADDR);
    assign r_resp_ph = (rstate == R_RESP);

    assign slave.aw_valid = aw_fwd && (wgnt ? master1.aw_valid : master0.aw_valid);
    assign slave.aw_addr  = wgnt ? master1.aw_addr : master0.aw_addr;
    assign slave.w_valid  = w_fwd && (wgnt ? master1.w_valid : master0.w_valid);
    assign slave.w_data   = wgnt ? master1.w_data : master0.w_data;
    assign slave.w_strb   = wgnt ? master1.w_strb : master0.w_strb;
    assign slave.b_ready  = w_resp_ph && (wgnt ? master1.b_ready : master0.b_ready);
    assign slave.ar_valid = r_addr_ph && (rgnt ? master1.ar_valid : master0.ar_valid);
    assign slave.ar_addr  = rgnt ? master1.ar_addr : master0.ar_addr;
    assign slave.r_ready  = r_resp_ph && (rgnt ? master1.r_ready : master0.r_ready);

    assign master0.aw_ready = aw_fwd && !wgnt && slave.aw_ready;
    assign master1.aw_ready = aw_fwd &&  wgnt && slave.aw_ready;
    assign master0.w_ready  = w_fwd  && !wgnt && slave.w_ready;
    assign master1.w_ready  = w_fwd  &&  wgnt && slave.w_ready;
    assign master0.b_valid  = w_resp_ph && !wgnt && slave.b_valid;
    assign master1.b_valid  = w_resp_ph &&  wgnt && slave.b_valid;
    assign master0.b_resp   = slave.b_resp;
    assign master1.b_resp   = slave.b_resp;
    assign master0.ar_ready = r_addr_ph && !rgnt && slave.ar_ready;
    assign master1.ar_ready = r_addr_ph &&  rgnt && slave.ar_ready;
    assign master0.r_valid  = r_resp_ph && !rgnt && slave.r_valid;
    assign master1.r_valid  = r_resp_ph &&  rgnt && slave.r_valid;
    assign master0.r_data   = slave.r_data;
    assign master1.r_data   = slave.r_data;
    assign master0.r_resp   = slave.r_resp;
    assign master1.r_resp   = slave.r_resp;

    assign aw_hs = slave.aw_valid && slave.aw_ready;
    assign w_hs  = slave.w_valid  && slave.w_ready;
    assign b_hs  = slave.b_valid  && slave.b_ready;
    assign ar_hs = slave.ar_valid && slave.ar_ready;
    assign r_hs  = slave.r_valid  && slave.r_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate  <= W_IDLE;
            wgnt    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
            wprio   <= 1'b0;
`endif
        end else begin
            case (wstate)
                W_IDLE: if (master0.aw_valid || master1.aw_valid) begin
                    wgnt   <= wgnt_next;
                    wstate <= W_ADDR;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) wstate <= W_RESP;
                end
                W_RESP: if (b_hs) begin
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
                    wprio   <= !wgnt;
`endif
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    wstate  <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate <= R_IDLE;
            rgnt   <= 1'b0;
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
            rprio  <= 1'b0;
`endif
        end else begin
            case (rstate)
                R_IDLE: if (master0.ar_valid || master1.ar_valid) begin
                    rgnt   <= rgnt_next;
                    rstate <= R_ADDR;
                end
                R_ADDR: if (ar_hs) rstate <= R_RESP;
                R_RESP: if (r_hs) begin
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
                    rprio  <= !rgnt;
`endif
                    rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
